// File: rtl/fetch_issue_unit.sv
// Instruction fetch and issue front end: one outstanding imem request, a one-entry
// skid buffer for stalled responses, branch redirect with stale-response discard, HALT stop.
module fetch_issue_unit #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned INSTR_WIDTH  = 32,
    parameter int unsigned OPCODE_WIDTH = 5,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 5'b10010
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stallD,
    input  logic                    flushD,
    input  logic                    branchTakenE,
    input  logic [ADDR_WIDTH-1:0]   branchTargetE,
    output logic                    imemReq,
    output logic [ADDR_WIDTH-1:0]   imemAddr,
    input  logic                    imemGrant,
    input  logic                    imemValid,
    input  logic [INSTR_WIDTH-1:0]  imemData,
    output logic [INSTR_WIDTH-1:0]  instrD,
    output logic [OPCODE_WIDTH-1:0] opcodeD,
    output logic [ADDR_WIDTH-1:0]   pcD,
    output logic                    validD,
    output logic                    halted
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StBuf, StHalt} state_e;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    pc_f_q, pc_f_d;
    logic [ADDR_WIDTH-1:0]    req_pc_q, req_pc_d;
    logic                     discard_q, discard_d;
    logic [INSTR_WIDTH-1:0]   buf_instr_q, buf_instr_d;
    logic [ADDR_WIDTH-1:0]    buf_pc_q, buf_pc_d;
    logic [INSTR_WIDTH-1:0]   dec_instr_q, dec_instr_d;
    logic [ADDR_WIDTH-1:0]    dec_pc_q, dec_pc_d;
    logic                     dec_valid_q, dec_valid_d;

    logic                     deliver;
    logic [INSTR_WIDTH-1:0]   del_word;
    logic [ADDR_WIDTH-1:0]    del_pc;

    always_comb begin
        state_d     = state_q;
        pc_f_d      = pc_f_q;
        req_pc_d    = req_pc_q;
        discard_d   = discard_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        dec_instr_d = stallD ? dec_instr_q : '0;
        dec_valid_d = stallD ? dec_valid_q : 1'b0;
        dec_pc_d    = dec_pc_q;
        deliver     = 1'b0;
        del_word    = '0;
        del_pc      = '0;

        if (branchTakenE) begin
            pc_f_d      = branchTargetE;
            dec_instr_d = '0;
            dec_valid_d = 1'b0;
            buf_instr_d = '0;
            buf_pc_d    = '0;
            // A response still in flight (or granted right now) must be swallowed later.
            if ((state_q == StWait && !imemValid) || (state_q == StReq && imemGrant)) begin
                discard_d = 1'b1;
                state_d   = StWait;
            end else begin
                discard_d = 1'b0;
                state_d   = StReq;
            end
        end else begin
            unique case (state_q)
                StIdle: state_d = StReq;
                StReq: begin
                    if (imemGrant) begin
                        req_pc_d = pc_f_q;
                        pc_f_d   = pc_f_q + 1'b1;
                        state_d  = StWait;
                    end
                end
                StWait: begin
                    if (imemValid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = StReq;
                        end else if (stallD || flushD) begin
                            buf_instr_d = imemData;
                            buf_pc_d    = req_pc_q;
                            state_d     = StBuf;
                        end else begin
                            deliver  = 1'b1;
                            del_word = imemData;
                            del_pc   = req_pc_q;
                        end
                    end
                end
                StBuf: begin
                    if (!stallD && !flushD) begin
                        deliver  = 1'b1;
                        del_word = buf_instr_q;
                        del_pc   = buf_pc_q;
                    end
                end
                StHalt: state_d = StHalt;
                default: state_d = StIdle;
            endcase

            if (deliver) begin
                dec_instr_d = del_word;
                dec_pc_d    = del_pc;
                dec_valid_d = 1'b1;
                state_d     = (del_word[INSTR_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE) ?
                              StHalt : StReq;
            end
            if (flushD) begin
                dec_instr_d = '0;
                dec_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_f_q      <= '0;
            req_pc_q    <= '0;
            discard_q   <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            dec_instr_q <= '0;
            dec_pc_q    <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_f_q      <= pc_f_d;
            req_pc_q    <= req_pc_d;
            discard_q   <= discard_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
            dec_valid_q <= dec_valid_d;
        end
    end

    assign imemReq  = (state_q == StReq);
    assign imemAddr = pc_f_q;
    assign instrD   = dec_instr_q;
    assign opcodeD  = dec_instr_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign pcD      = dec_pc_q;
    assign validD   = dec_valid_q;
    assign halted   = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed bench for fetch_issue_unit: fetch sequence, stall buffering, redirects,
// address wrap, flush with buffering, HALT and asynchronous reset.
module tb_fetch_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stallD = 1'b0;
    logic        flushD = 1'b0;
    logic        branchTakenE = 1'b0;
    logic [9:0]  branchTargetE = '0;
    logic        imemReq;
    logic [9:0]  imemAddr;
    logic        imemGrant = 1'b0;
    logic        imemValid = 1'b0;
    logic [31:0] imemData = '0;
    logic [31:0] instrD;
    logic [4:0]  opcodeD;
    logic [9:0]  pcD;
    logic        validD;
    logic        halted;

    int n_checks = 0;
    int n_fail = 0;

    fetch_issue_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stallD       (stallD),
        .flushD       (flushD),
        .branchTakenE (branchTakenE),
        .branchTargetE(branchTargetE),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemGrant    (imemGrant),
        .imemValid    (imemValid),
        .imemData     (imemData),
        .instrD       (instrD),
        .opcodeD      (opcodeD),
        .pcD          (pcD),
        .validD       (validD),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One granted request followed by its response the next cycle, no stall.
    task automatic fetch(input string tag, input logic [9:0] addr, input logic [31:0] word);
        chk({tag, ".req"}, 32'(imemReq), 32'd1);
        chk({tag, ".addr"}, 32'(imemAddr), 32'(addr));
        imemGrant = 1'b1;
        cyc();
        imemGrant = 1'b0;
        chk({tag, ".wait_noreq"}, 32'(imemReq), 32'd0);
        imemValid = 1'b1;
        imemData  = word;
        cyc();
        imemValid = 1'b0;
        chk({tag, ".instr"}, instrD, word);
        chk({tag, ".pcD"}, 32'(pcD), 32'(addr));
        chk({tag, ".validD"}, 32'(validD), 32'd1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst.req", 32'(imemReq), 32'd0);
        chk("rst.addr", 32'(imemAddr), 32'd0);
        chk("rst.instr", instrD, 32'd0);
        chk("rst.opcode", 32'(opcodeD), 32'd0);
        chk("rst.pcD", 32'(pcD), 32'd0);
        chk("rst.validD", 32'(validD), 32'd0);
        chk("rst.halted", 32'(halted), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        chk("idle.req", 32'(imemReq), 32'd0);
        cyc();

        // Straight-line fetch of addresses 0..2
        fetch("seq0", 10'd0, 32'h0800_0000);
        chk("seq0.opcode", 32'(opcodeD), 32'd1);
        fetch("seq1", 10'd1, 32'h0800_0000);
        fetch("seq2", 10'd2, 32'h0800_0000);
        chk("seq2.opcode", 32'(opcodeD), 32'd1);

        // No delivery and no stall: bubble, pcD holds, address stable without grant
        cyc();
        chk("bubble.validD", 32'(validD), 32'd0);
        chk("bubble.instr", instrD, 32'd0);
        chk("bubble.pcD", 32'(pcD), 32'd2);
        chk("bubble.addr", 32'(imemAddr), 32'd3);
        fetch("seq3", 10'd3, 32'h1000_0003);
        chk("seq3.opcode", 32'(opcodeD), 32'd2);

        // Stall 3 cycles while the response for address 4 arrives
        stallD = 1'b1;
        chk("stall.addr", 32'(imemAddr), 32'd4);
        imemGrant = 1'b1;
        cyc();
        imemGrant = 1'b0;
        imemValid = 1'b1;
        imemData  = 32'h1800_0004;
        cyc();
        imemValid = 1'b0;
        chk("buf.req", 32'(imemReq), 32'd0);
        chk("buf.instr", instrD, 32'h1000_0003);
        chk("buf.validD", 32'(validD), 32'd1);
        cyc();
        chk("buf2.req", 32'(imemReq), 32'd0);
        chk("buf2.instr", instrD, 32'h1000_0003);
        stallD = 1'b0;
        cyc();
        chk("unbuf.instr", instrD, 32'h1800_0004);
        chk("unbuf.pcD", 32'(pcD), 32'd4);
        chk("unbuf.validD", 32'(validD), 32'd1);
        chk("unbuf.req", 32'(imemReq), 32'd1);
        chk("unbuf.addr", 32'(imemAddr), 32'd5);

        // Branch while waiting: stale response (with HALT opcode) must be dropped
        stallD = 1'b1;
        imemGrant = 1'b1;
        cyc();
        imemGrant = 1'b0;
        stallD = 1'b0;
        branchTakenE = 1'b1;
        branchTargetE = 10'h020;
        cyc();
        branchTakenE = 1'b0;
        chk("br.validD", 32'(validD), 32'd0);
        chk("br.instr", instrD, 32'd0);
        chk("br.req", 32'(imemReq), 32'd0);
        imemValid = 1'b1;
        imemData  = 32'h9000_0005;
        cyc();
        imemValid = 1'b0;
        chk("br.drop_validD", 32'(validD), 32'd0);
        chk("br.drop_halted", 32'(halted), 32'd0);
        chk("br.req2", 32'(imemReq), 32'd1);
        chk("br.addr", 32'(imemAddr), 32'h020);

        // Branch in the same cycle as a grant: that response is discarded too
        imemGrant = 1'b1;
        branchTakenE = 1'b1;
        branchTargetE = 10'h3FF;
        cyc();
        imemGrant = 1'b0;
        branchTakenE = 1'b0;
        chk("brg.req", 32'(imemReq), 32'd0);
        imemValid = 1'b1;
        imemData  = 32'h0800_0000;
        cyc();
        imemValid = 1'b0;
        chk("brg.validD", 32'(validD), 32'd0);
        chk("brg.addr", 32'(imemAddr), 32'h3FF);

        // Address wrap
        fetch("wrap", 10'h3FF, 32'h2000_0000);
        chk("wrap.next_addr", 32'(imemAddr), 32'd0);

        // Flush plus stall while the response arrives: bubble now, word buffered
        stallD = 1'b1;
        imemGrant = 1'b1;
        cyc();
        imemGrant = 1'b0;
        chk("flush.pre_valid", 32'(validD), 32'd1);
        flushD = 1'b1;
        imemValid = 1'b1;
        imemData  = 32'h2800_0000;
        cyc();
        flushD = 1'b0;
        imemValid = 1'b0;
        chk("flush.instr", instrD, 32'd0);
        chk("flush.validD", 32'(validD), 32'd0);
        chk("flush.req", 32'(imemReq), 32'd0);
        cyc();
        chk("flush.hold_validD", 32'(validD), 32'd0);
        stallD = 1'b0;
        cyc();
        chk("flush.deliver_instr", instrD, 32'h2800_0000);
        chk("flush.deliver_pcD", 32'(pcD), 32'd0);
        chk("flush.deliver_validD", 32'(validD), 32'd1);
        chk("flush.next_addr", 32'(imemAddr), 32'd1);

        // HALT at address 7
        branchTakenE = 1'b1;
        branchTargetE = 10'd7;
        cyc();
        branchTakenE = 1'b0;
        fetch("halt", 10'd7, 32'h9000_0000);
        chk("halt.halted", 32'(halted), 32'd1);
        chk("halt.req", 32'(imemReq), 32'd0);
        chk("halt.opcode", 32'(opcodeD), 32'h12);
        imemValid = 1'b1;
        imemData  = 32'h0800_0000;
        cyc();
        imemValid = 1'b0;
        chk("halt.ignore_valid", 32'(validD), 32'd0);
        chk("halt.still", 32'(halted), 32'd1);
        imemGrant = 1'b1;
        cyc();
        imemGrant = 1'b0;
        chk("halt.req2", 32'(imemReq), 32'd0);
        chk("halt.addr", 32'(imemAddr), 32'd8);
        branchTakenE = 1'b1;
        branchTargetE = 10'd0;
        cyc();
        branchTakenE = 1'b0;
        chk("unhalt.halted", 32'(halted), 32'd0);
        chk("unhalt.addr", 32'(imemAddr), 32'd0);
        chk("unhalt.req", 32'(imemReq), 32'd1);

        // Asynchronous reset in the middle of a transaction
        imemGrant = 1'b1;
        cyc();
        imemGrant = 1'b0;
        chk("mid.addr_before", 32'(imemAddr), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid.req", 32'(imemReq), 32'd0);
        chk("mid.addr", 32'(imemAddr), 32'd0);
        chk("mid.pcD", 32'(pcD), 32'd0);
        chk("mid.validD", 32'(validD), 32'd0);
        chk("mid.halted", 32'(halted), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("mid.restart_req", 32'(imemReq), 32'd1);
        chk("mid.restart_addr", 32'(imemAddr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
